// File: rtl/otter_hazard_ctrl_if.sv
// Hazard-control bundle: ID/EX/MEM hazard inputs and the stall/flush/forward controls.
// There is no handshake here: every signal is a level sampled each cycle, and nothing waits on anything else.
interface otter_hazard_ctrl_if #(
    parameter int RW = 5,
    parameter int CW = 32
);
    logic [RW-1:0] id_rs1;
    logic [RW-1:0] id_rs2;
    logic          id_rs1_used;
    logic          id_rs2_used;
    logic [RW-1:0] ex_rd;
    logic          ex_reg_wr;
    logic          ex_mem_rd;
    logic [RW-1:0] mem_rd;
    logic          mem_reg_wr;
    logic          ex_br_taken;
    logic          stall_ext;
    logic          cnt_clr;
    logic [1:0]    fwd_a_sel;
    logic [1:0]    fwd_b_sel;
    logic          stall_pc;
    logic          stall_ifid;
    logic          flush_ifid;
    logic          flush_idex;
    logic [1:0]    hz_state;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;
    logic          err;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_reg_wr, ex_mem_rd,
               mem_rd, mem_reg_wr, ex_br_taken, stall_ext, cnt_clr,
        input  fwd_a_sel, fwd_b_sel, stall_pc, stall_ifid, flush_ifid, flush_idex,
               hz_state, stall_cnt, flush_cnt, err
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_reg_wr, ex_mem_rd,
               mem_rd, mem_reg_wr, ex_br_taken, stall_ext, cnt_clr,
        output fwd_a_sel, fwd_b_sel, stall_pc, stall_ifid, flush_ifid, flush_idex,
               hz_state, stall_cnt, flush_cnt, err
    );
endinterface

// File: rtl/otter_hazard_ctrl.sv
// OTTER pipeline hazard unit: operand forwarding selects, load-use stall, branch flush,
// saturating debug counters and a sticky back-to-back load-use error flag.
module otter_hazard_ctrl #(
    parameter int RW = 5,
    parameter int CW = 32
) (
    input logic               clk,
    input logic               rst_n,
    otter_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_LDSTALL = 2'b01,
        ST_FLUSH   = 2'b10
    } hz_state_t;

    hz_state_t     state_q, state_nxt;
    logic [1:0]    fwd_a_q, fwd_b_q;
    logic [1:0]    fwd_a_nxt, fwd_b_nxt;
    logic [CW-1:0] stall_cnt_q, flush_cnt_q;
    logic          err_q;

    logic ex_m1, ex_m2, mem_m1, mem_m2;
    logic ld;
    logic stall_issue, flush_issue;
    logic stall_pc_c, stall_ifid_c, flush_ifid_c, flush_idex_c;

    // x0 is hardwired to zero, so a write to it never counts as a match.
    assign ex_m1  = hz.ex_reg_wr & (hz.ex_rd == hz.id_rs1) & (hz.ex_rd != '0) & hz.id_rs1_used;
    assign ex_m2  = hz.ex_reg_wr & (hz.ex_rd == hz.id_rs2) & (hz.ex_rd != '0) & hz.id_rs2_used;
    assign mem_m1 = hz.mem_reg_wr & (hz.mem_rd == hz.id_rs1) & (hz.mem_rd != '0) & hz.id_rs1_used;
    assign mem_m2 = hz.mem_reg_wr & (hz.mem_rd == hz.id_rs2) & (hz.mem_rd != '0) & hz.id_rs2_used;
    assign ld     = hz.ex_mem_rd & (ex_m1 | ex_m2);

    assign fwd_a_nxt = (ex_m1 & ~hz.ex_mem_rd) ? 2'b01 : (mem_m1 ? 2'b10 : 2'b00);
    assign fwd_b_nxt = (ex_m2 & ~hz.ex_mem_rd) ? 2'b01 : (mem_m2 ? 2'b10 : 2'b00);

    // Events that actually take effect this cycle; an external freeze suppresses both.
    assign flush_issue = hz.ex_br_taken & ~hz.stall_ext;
    assign stall_issue = ld & ~hz.ex_br_taken & ~hz.stall_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        if (!hz.stall_ext) begin
            if (flush_issue)      state_nxt = ST_FLUSH;
            else if (stall_issue) state_nxt = ST_LDSTALL;
            else                  state_nxt = ST_RUN;
        end
    end

    always_comb begin
        stall_pc_c   = 1'b0;
        stall_ifid_c = 1'b0;
        flush_ifid_c = 1'b0;
        flush_idex_c = 1'b0;
        if (hz.stall_ext) begin
            stall_pc_c   = 1'b1;
            stall_ifid_c = 1'b1;
        end else if (hz.ex_br_taken) begin
            flush_ifid_c = 1'b1;
            flush_idex_c = 1'b1;
        end else if (ld) begin
            stall_pc_c   = 1'b1;
            stall_ifid_c = 1'b1;
            flush_idex_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else if (!hz.stall_ext) begin
            fwd_a_q <= flush_idex_c ? 2'b00 : fwd_a_nxt;
            fwd_b_q <= flush_idex_c ? 2'b00 : fwd_b_nxt;
        end
    end

    // Clear wins over increment and is honoured even while frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (hz.cnt_clr) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_issue && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CW'(1);
            if (flush_issue && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CW'(1);
        end
    end

    // A bubble sits in EX after a load-use stall, so a second one in a row means broken wiring.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (ld && (state_q == ST_LDSTALL) && !hz.stall_ext) begin
            err_q <= 1'b1;
        end
    end

    assign hz.fwd_a_sel  = fwd_a_q;
    assign hz.fwd_b_sel  = fwd_b_q;
    assign hz.stall_pc   = stall_pc_c;
    assign hz.stall_ifid = stall_ifid_c;
    assign hz.flush_ifid = flush_ifid_c;
    assign hz.flush_idex = flush_idex_c;
    assign hz.hz_state   = state_q;
    assign hz.stall_cnt  = stall_cnt_q;
    assign hz.flush_cnt  = flush_cnt_q;
    assign hz.err        = err_q;
endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Directed bench for otter_hazard_ctrl; 4-bit counters so saturation is reachable quickly.
module tb_otter_hazard_ctrl;
    localparam int RW = 5;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    otter_hazard_ctrl_if #(.RW(RW), .CW(CW)) hz ();

    otter_hazard_ctrl #(.RW(RW), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz.slave)
    );

    always #5 clk = ~clk;

    // {stall_pc, stall_ifid, flush_ifid, flush_idex}
    logic [3:0] ctl;
    assign ctl = {hz.stall_pc, hz.stall_ifid, hz.flush_ifid, hz.flush_idex};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_rs1_used = 1'b0; hz.id_rs2_used = 1'b0;
        hz.ex_rd = '0; hz.ex_reg_wr = 1'b0; hz.ex_mem_rd = 1'b0;
        hz.mem_rd = '0; hz.mem_reg_wr = 1'b0;
        hz.ex_br_taken = 1'b0; hz.stall_ext = 1'b0; hz.cnt_clr = 1'b0;
    endtask

    task automatic set_load_use(input logic [RW-1:0] rd);
        hz.ex_mem_rd = 1'b1; hz.ex_reg_wr = 1'b1; hz.ex_rd = rd;
        hz.id_rs2 = rd; hz.id_rs2_used = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        #12;
        checks++; if (hz.fwd_a_sel !== 2'b00) begin failures++; $display("FAIL reset_fwd_a got=%0h exp=0", hz.fwd_a_sel); end
        checks++; if (hz.fwd_b_sel !== 2'b00) begin failures++; $display("FAIL reset_fwd_b got=%0h exp=0", hz.fwd_b_sel); end
        checks++; if (hz.hz_state !== 2'b00) begin failures++; $display("FAIL reset_state got=%0h exp=0", hz.hz_state); end
        checks++; if ({hz.stall_cnt, hz.flush_cnt, hz.err} !== '0) begin failures++; $display("FAIL reset_cnt_err got=%0h/%0h/%0b exp=0", hz.stall_cnt, hz.flush_cnt, hz.err); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_forward();
        clear_inputs();
        hz.ex_rd = 5'd5; hz.ex_reg_wr = 1'b1; hz.id_rs1 = 5'd5; hz.id_rs1_used = 1'b1;
        #1;
        checks++; if (ctl !== 4'b0000) begin failures++; $display("FAIL fwd_ex_ctl got=%b exp=0000", ctl); end
        tick();
        checks++; if (hz.fwd_a_sel !== 2'b01) begin failures++; $display("FAIL fwd_ex_a got=%0h exp=1", hz.fwd_a_sel); end
        checks++; if (hz.fwd_b_sel !== 2'b00) begin failures++; $display("FAIL fwd_ex_b got=%0h exp=0", hz.fwd_b_sel); end
        // EX and MEM both match rs1 (EX wins); MEM alone matches rs2.
        hz.mem_rd = 5'd5; hz.mem_reg_wr = 1'b1;
        hz.id_rs2 = 5'd9; hz.id_rs2_used = 1'b1;
        tick();
        hz.mem_rd = 5'd9;
        tick();
        checks++; if (hz.fwd_a_sel !== 2'b01) begin failures++; $display("FAIL fwd_prio_a got=%0h exp=1", hz.fwd_a_sel); end
        checks++; if (hz.fwd_b_sel !== 2'b10) begin failures++; $display("FAIL fwd_mem_b got=%0h exp=2", hz.fwd_b_sel); end
        clear_inputs();
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs();
        set_load_use(5'd7);
        #1;
        checks++; if (ctl !== 4'b1101) begin failures++; $display("FAIL ld_ctl got=%b exp=1101", ctl); end
        tick();
        checks++; if (hz.hz_state !== 2'b01) begin failures++; $display("FAIL ld_state got=%0h exp=1", hz.hz_state); end
        checks++; if (hz.stall_cnt !== 4'd1) begin failures++; $display("FAIL ld_stall_cnt got=%0d exp=1", hz.stall_cnt); end
        checks++; if (hz.fwd_b_sel !== 2'b00) begin failures++; $display("FAIL ld_fwd_b got=%0h exp=0", hz.fwd_b_sel); end
        hz.ex_mem_rd = 1'b0; hz.ex_reg_wr = 1'b0; hz.ex_rd = '0;
        hz.mem_rd = 5'd7; hz.mem_reg_wr = 1'b1;
        #1;
        checks++; if (ctl !== 4'b0000) begin failures++; $display("FAIL ld_shift_ctl got=%b exp=0000", ctl); end
        tick();
        checks++; if (hz.fwd_b_sel !== 2'b10) begin failures++; $display("FAIL ld_shift_fwd_b got=%0h exp=2", hz.fwd_b_sel); end
        checks++; if (hz.hz_state !== 2'b00) begin failures++; $display("FAIL ld_shift_state got=%0h exp=0", hz.hz_state); end
        clear_inputs();
        tick();
    endtask

    task automatic test_branch_ld();
        clear_inputs();
        set_load_use(5'd7);
        hz.ex_br_taken = 1'b1;
        #1;
        checks++; if (ctl !== 4'b0011) begin failures++; $display("FAIL br_ld_ctl got=%b exp=0011", ctl); end
        tick();
        checks++; if (hz.flush_cnt !== 4'd1) begin failures++; $display("FAIL br_flush_cnt got=%0d exp=1", hz.flush_cnt); end
        checks++; if (hz.stall_cnt !== 4'd1) begin failures++; $display("FAIL br_stall_cnt got=%0d exp=1", hz.stall_cnt); end
        checks++; if (hz.hz_state !== 2'b10) begin failures++; $display("FAIL br_state got=%0h exp=2", hz.hz_state); end
        clear_inputs();
        tick();
    endtask

    task automatic test_x0_unused();
        clear_inputs();
        hz.ex_rd = 5'd0; hz.ex_reg_wr = 1'b1; hz.ex_mem_rd = 1'b1; hz.id_rs1 = 5'd0; hz.id_rs1_used = 1'b1;
        hz.mem_rd = 5'd0; hz.mem_reg_wr = 1'b1;
        #1;
        checks++; if (ctl !== 4'b0000) begin failures++; $display("FAIL x0_ctl got=%b exp=0000", ctl); end
        tick();
        checks++; if (hz.fwd_a_sel !== 2'b00) begin failures++; $display("FAIL x0_fwd_a got=%0h exp=0", hz.fwd_a_sel); end
        hz.ex_mem_rd = 1'b0;
        tick();
        checks++; if (hz.fwd_a_sel !== 2'b00) begin failures++; $display("FAIL x0_nold_fwd_a got=%0h exp=0", hz.fwd_a_sel); end
        hz.ex_rd = 5'd3; hz.id_rs1 = 5'd3; hz.id_rs1_used = 1'b0; hz.ex_mem_rd = 1'b1;
        #1;
        checks++; if (ctl !== 4'b0000) begin failures++; $display("FAIL unused_ctl got=%b exp=0000", ctl); end
        hz.ex_mem_rd = 1'b0;
        tick();
        checks++; if (hz.fwd_a_sel !== 2'b00) begin failures++; $display("FAIL unused_fwd_a got=%0h exp=0", hz.fwd_a_sel); end
        clear_inputs();
        tick();
    endtask

    task automatic test_stall_ext();
        clear_inputs();
        hz.ex_rd = 5'd5; hz.ex_reg_wr = 1'b1; hz.id_rs1 = 5'd5; hz.id_rs1_used = 1'b1;
        tick();
        hz.id_rs1 = 5'd6;
        hz.ex_br_taken = 1'b1; hz.stall_ext = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ctl !== 4'b1100) begin failures++; $display("FAIL frz_ctl[%0d] got=%b exp=1100", i, ctl); end
            tick();
            checks++; if (hz.flush_cnt !== 4'd1) begin failures++; $display("FAIL frz_flush_cnt[%0d] got=%0d exp=1", i, hz.flush_cnt); end
            checks++; if (hz.fwd_a_sel !== 2'b01) begin failures++; $display("FAIL frz_fwd_a[%0d] got=%0h exp=1", i, hz.fwd_a_sel); end
        end
        hz.stall_ext = 1'b0;
        #1;
        checks++; if (ctl !== 4'b0011) begin failures++; $display("FAIL frz_rel_ctl got=%b exp=0011", ctl); end
        tick();
        checks++; if (hz.flush_cnt !== 4'd2) begin failures++; $display("FAIL frz_rel_flush_cnt got=%0d exp=2", hz.flush_cnt); end
        checks++; if (hz.hz_state !== 2'b10) begin failures++; $display("FAIL frz_rel_state got=%0h exp=2", hz.hz_state); end
        checks++; if (hz.fwd_a_sel !== 2'b00) begin failures++; $display("FAIL frz_rel_fwd_a got=%0h exp=0", hz.fwd_a_sel); end
        clear_inputs();
        tick();
    endtask

    task automatic test_saturation();
        clear_inputs();
        hz.cnt_clr = 1'b1;
        tick();
        checks++; if (hz.stall_cnt !== 4'd0) begin failures++; $display("FAIL sat_clr0 got=%0d exp=0", hz.stall_cnt); end
        hz.cnt_clr = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            set_load_use(5'd4);
            tick();
            clear_inputs();
            tick();
            if (i >= 15) begin
                checks++; if (hz.stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_cnt[%0d] got=%0d exp=15", i, hz.stall_cnt); end
            end
        end
        checks++; if (hz.err !== 1'b0) begin failures++; $display("FAIL sat_err got=%0b exp=0", hz.err); end
        set_load_use(5'd4);
        hz.cnt_clr = 1'b1;
        tick();
        checks++; if (hz.stall_cnt !== 4'd0) begin failures++; $display("FAIL sat_clr_prio got=%0d exp=0", hz.stall_cnt); end
        checks++; if (hz.flush_cnt !== 4'd0) begin failures++; $display("FAIL sat_clr_flush got=%0d exp=0", hz.flush_cnt); end
        clear_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        set_load_use(5'd8);
        tick();
        checks++; if (hz.err !== 1'b0) begin failures++; $display("FAIL b2b_err_first got=%0b exp=0", hz.err); end
        tick();
        checks++; if (hz.err !== 1'b1) begin failures++; $display("FAIL b2b_err_set got=%0b exp=1", hz.err); end
        checks++; if (hz.stall_cnt !== 4'd2) begin failures++; $display("FAIL b2b_stall_cnt got=%0d exp=2", hz.stall_cnt); end
        clear_inputs();
        tick();
        checks++; if (hz.err !== 1'b1) begin failures++; $display("FAIL b2b_err_sticky got=%0b exp=1", hz.err); end
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        hz.ex_br_taken = 1'b1;
        tick();
        set_load_use(5'd9);
        hz.ex_br_taken = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (ctl !== 4'b1101) begin failures++; $display("FAIL rst_mid_ctl got=%b exp=1101", ctl); end
        checks++; if (hz.hz_state !== 2'b00) begin failures++; $display("FAIL rst_mid_state got=%0h exp=0", hz.hz_state); end
        checks++; if ({hz.stall_cnt, hz.flush_cnt, hz.err, hz.fwd_a_sel, hz.fwd_b_sel} !== '0) begin
            failures++; $display("FAIL rst_mid_regs got=%0h/%0h/%0b exp=0", hz.stall_cnt, hz.flush_cnt, hz.err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_branch_ld();
        test_x0_unused();
        test_stall_ext();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/otter_hazard_ctrl.md
# otter_hazard_ctrl

Hazard control unit for the pipelined OTTER RV32I core. It drives the forwarding-mux select lines at the EX operand inputs and issues the PC/IF-ID stall and IF-ID/ID-EX flush controls. It sits beside the ID stage, reads register addresses and control bits from ID, EX and MEM, and registers forwarding decisions into the ID/EX boundary. It also keeps saturating stall and flush event counters for debug.

## Interface
- RW, 5: register-address width.
- CW, 32: event-counter width.

- CLK  in  1  core clock; all state updates on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- ID_RS1, ID_RS2  in  RW  source registers of the instruction in ID.
- ID_RS1_USED, ID_RS2_USED  in  1  the ID instruction actually reads rs1/rs2.
- EX_RD  in  RW  destination register of the instruction in EX.
- EX_REG_WR  in  1  EX instruction writes the register file.
- EX_MEM_RD  in  1  EX instruction is a load.
- MEM_RD  in  RW  destination register of the instruction in MEM.
- MEM_REG_WR  in  1  MEM instruction writes the register file.
- EX_BR_TAKEN  in  1  branch or jump resolved taken in EX.
- STALL_EXT  in  1  external freeze, such as a memory wait.
- CNT_CLR  in  1  synchronous clear of both counters.
- FWD_A_SEL, FWD_B_SEL  out  2  registered operand select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result.
- STALL_PC, STALL_IFID  out  1  combinational hold of PC and the IF/ID register.
- FLUSH_IFID, FLUSH_IDEX  out  1  combinational bubble insert.
- HZ_STATE  out  2  registered last-cycle event: 00 RUN, 01 LDSTALL, 10 FLUSH.
- STALL_CNT, FLUSH_CNT  out  CW  saturating event counters.
- ERR  out  1  sticky protocol-violation flag.

## Operation
- Address match: for X in {EX, MEM}, matchX(rs) = X_REG_WR & (X_RD == rs) & (X_RD != 0) & rs_used.
- Load-use: ld = EX_MEM_RD & (matchEX(rs1) | matchEX(rs2)).
- Next forwarding select, per operand, in priority order:
  - matchEX & !EX_MEM_RD gives 01.
  - Otherwise matchMEM gives 10.
  - Otherwise 00.
- Event priority, highest first:
  - STALL_EXT: STALL_PC = STALL_IFID = 1; both flushes 0; all registers hold, except CNT_CLR still applies.
  - EX_BR_TAKEN: FLUSH_IFID = FLUSH_IDEX = 1; stalls 0; any simultaneous ld is ignored because the ID instruction is being squashed.
  - ld: STALL_PC = STALL_IFID = FLUSH_IDEX = 1; FLUSH_IFID = 0.
  - None of the above: all four control outputs 0.
- FWD_*_SEL register: loads 00 when FLUSH_IDEX is 1; otherwise loads the next-select value.
- HZ_STATE FSM, updated each unfrozen cycle:
  - Goes to FLUSH if a branch flush was issued.
  - Else goes to LDSTALL if a load-use stall was issued.
  - Else goes to RUN.
- Counters:
  - STALL_CNT increments on an unfrozen cycle with a load-use stall.
  - FLUSH_CNT increments on an unfrozen cycle with a branch flush.
  - Both saturate at all-ones.
  - CNT_CLR has priority over increment.
- ERR is set when ld is asserted while HZ_STATE = LDSTALL and STALL_EXT = 0. A back-to-back load-use is impossible with a bubble in EX, so this flags broken pipeline wiring. ERR is cleared only by reset.
- x0 rule: RW'b0 never matches, so writes to x0 are never forwarded.

## Timing
- Reset, asynchronous: FWD_*_SEL = 00, HZ_STATE = RUN, counters = 0, ERR = 0.
- Reset mid-stall: combinational outputs follow their inputs immediately; registered state returns to reset values at once.
- Stall and flush outputs have zero latency and are valid in the same cycle as their inputs.
- Forwarding selects have one-cycle latency: a value decided with the instruction in ID is presented while that instruction is in EX.
- A stalled instruction is re-evaluated next cycle. The load is then in MEM, so the select resolves to 10.
- HZ_STATE, counters and ERR reflect the previous cycle.

## Test plan
- Forwarding from EX/MEM: EX_RD=5, EX_REG_WR=1, ID_RS1=5, used -> next cycle FWD_A_SEL=01, FWD_B_SEL=00, no stall.
- Load-use: EX_MEM_RD=1, EX_RD=7, ID_RS2=7, used -> STALL_PC=STALL_IFID=FLUSH_IDEX=1 in the same cycle. Next cycle HZ_STATE=01, STALL_CNT=1, FWD_B_SEL=00. After the pipeline shifts (MEM_RD=7), FWD_B_SEL=10.
- Branch with simultaneous load-use: EX_BR_TAKEN=1 and ld conditions true -> FLUSH_IFID=FLUSH_IDEX=1, STALL_PC=0. FLUSH_CNT=1, STALL_CNT unchanged, HZ_STATE=10.
- x0 and the unused flag: EX_RD=0 with ID_RS1=0, then EX_RD=3 with ID_RS1=3 and ID_RS1_USED=0 -> FWD_A_SEL=00 and no stall in both cases.
- STALL_EXT freeze: hold STALL_EXT=1 for 3 cycles during a branch -> no flush issued and counters frozen. Release -> flush is issued and FLUSH_CNT increments by 1.
- Saturation and clear: preload via CW=4 and 16 load-use events -> STALL_CNT=15. CNT_CLR=1 -> STALL_CNT=0 the next cycle. Mid-test RST_N low -> all registered outputs clear immediately.
